// File: rtl/des_sbox_sub_unit.sv
// ---------------------------------------------------------------------------
// des_sbox_sub_unit : DES S1..S8 substitution, LANES S-boxes looked up per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module des_sbox_sub_unit #(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int ITER  = 8 / LANES;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  // One 256-bit row-major table per S-box; entry index is {row, col}.
  localparam logic [0:7][0:63][3:0] SBOX_ROM = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [0:7][5:0]        data_q, data_d;
  logic [0:7][3:0]        result_q, result_d;

  logic [2:0]             lane_sel   [LANES];
  logic [5:0]             lane_chunk [LANES];
  logic [3:0]             lane_nib   [LANES];

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_sub_unit: LANES must be 1, 2, 4 or 8");
  end

  // Lane l of busy cycle c serves S-box c*LANES+l (0-based).
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_sel[l]   = 3'(int'(cnt_q) * LANES + l);
    assign lane_chunk[l] = data_q[lane_sel[l]];
    assign lane_nib[l]   = SBOX_ROM[lane_sel[l]][{lane_chunk[l][5], lane_chunk[l][0],
                                                   lane_chunk[l][4:1]}];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          result_d[lane_sel[l]] = lane_nib[l];
        end
        if (cnt_q == CNT_W'(ITER - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  assign out_data = result_q;

endmodule

`default_nettype wire
